// File: rtl/ftoi_ext.sv
`default_nettype none
// ============================================================================
//  Module   : ftoi_ext
//  Purpose  : IEEE-754 binary32 to OUT_W-bit integer converter, signed or
//             unsigned, with five rounding modes, saturation and invalid /
//             inexact flags. Two-stage pipeline with valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OUT_W      integer result width, 16..64
//  Ports
//    clk        sole clock, rising edge
//    reset      synchronous active-high reset
//    in_valid   op/rm/uns valid this cycle
//    in_ready   block accepts input this cycle
//    op         binary32 operand
//    rm         rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5..7 RNE
//    uns        1 = unsigned result, 0 = two's-complement signed result
//    out_valid  result/flags valid
//    out_ready  consumer accepts result
//    result     converted integer
//    nv         invalid flag (NaN, infinity, out of range)
//    nx         inexact flag (discarded fraction nonzero and nv = 0)
// ============================================================================
module ftoi_ext #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op,
    input  logic [2:0]       rm,
    input  logic             uns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             nv,
    output logic             nx
);

    // Fixed-point working width: OUT_W+1 integer bits (one spare bit so that
    // a magnitude of exactly 2^OUT_W is still representable) plus 24
    // fraction bits (guard at bit 23, sticky from bits 22..0).
    localparam int c_FW = OUT_W + 25;

    localparam logic [2:0] c_RM_RTZ = 3'd1;
    localparam logic [2:0] c_RM_RDN = 3'd2;
    localparam logic [2:0] c_RM_RUP = 3'd3;
    localparam logic [2:0] c_RM_RMM = 3'd4;

    // Range limits expressed on the OUT_W+2 bit post-rounding magnitude.
    localparam logic [OUT_W+1:0] c_SMAX_MAG = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W+1:0] c_SMIN_MAG = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W+1:0] c_UMAX_MAG = {2'b00, {OUT_W{1'b1}}};

    localparam logic [OUT_W-1:0] c_SMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_SMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] c_ONES = {OUT_W{1'b1}};

    localparam logic signed [9:0] c_EXP_LIMIT = 10'(OUT_W);

    // ------------------------------------------------------------------
    // Handshake: the whole pipeline moves together.
    // ------------------------------------------------------------------
    logic w_advance;

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------
    // Stage 1 combinational: split the operand into integer part, guard
    // and sticky.
    // ------------------------------------------------------------------
    logic [7:0]         w_exp_fld;
    logic [22:0]        w_fra;
    logic [23:0]        w_mant;
    logic signed [9:0]  w_exp_unb;
    logic               w_is_zero_exp;
    logic               w_is_nan;
    logic               w_huge;
    logic               w_tiny;
    logic [6:0]         w_shamt;
    logic [c_FW-1:0]    w_fix;
    logic [OUT_W:0]     w_int;
    logic               w_guard;
    logic               w_sticky;

    assign w_exp_fld     = op[30:23];
    assign w_fra         = op[22:0];
    assign w_mant        = {1'b1, w_fra};
    assign w_exp_unb     = $signed({2'b00, w_exp_fld}) - 10'sd127;
    assign w_is_zero_exp = (w_exp_fld == 8'h00);
    assign w_is_nan      = (w_exp_fld == 8'hFF) && (w_fra != 23'd0);
    // Beyond OUT_W the integer part cannot fit even before rounding;
    // infinity and NaN (unbiased exponent 128) land here as well.
    assign w_huge        = (w_exp_unb > c_EXP_LIMIT);
    // Below 2^-1 the whole value is sticky only.
    assign w_tiny        = (w_exp_unb < -10'sd1);

    always_comb begin
        w_shamt  = '0;
        w_fix    = '0;
        w_int    = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        if (w_is_zero_exp) begin
            // Zero and subnormals: magnitude 0, any fraction is sticky.
            w_sticky = |w_fra;
        end else if (w_huge) begin
            // Saturation is decided in stage 2 from the exponent alone.
            w_sticky = 1'b0;
        end else if (w_tiny) begin
            w_sticky = 1'b1;
        end else begin
            // Value = mant * 2^(E-23); with 24 fraction bits kept that is
            // mant << (E+1), where E+1 ranges over 0..OUT_W+1.
            w_shamt  = 7'(w_exp_unb + 10'sd1);
            w_fix    = {{(OUT_W+1){1'b0}}, w_mant} << w_shamt;
            w_int    = w_fix[c_FW-1:24];
            w_guard  = w_fix[23];
            w_sticky = |w_fix[22:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic               r1_valid;
    logic               r1_sign;
    logic signed [9:0]  r1_exp;
    logic [OUT_W:0]     r1_int;
    logic               r1_guard;
    logic               r1_sticky;
    logic [2:0]         r1_rm;
    logic               r1_uns;
    logic               r1_nan;

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid  <= 1'b0;
            r1_sign   <= 1'b0;
            r1_exp    <= '0;
            r1_int    <= '0;
            r1_guard  <= 1'b0;
            r1_sticky <= 1'b0;
            r1_rm     <= '0;
            r1_uns    <= 1'b0;
            r1_nan    <= 1'b0;
        end else if (w_advance) begin
            r1_valid  <= in_valid;
            r1_sign   <= op[31];
            r1_exp    <= w_exp_unb;
            r1_int    <= w_int;
            r1_guard  <= w_guard;
            r1_sticky <= w_sticky;
            r1_rm     <= rm;
            r1_uns    <= uns;
            r1_nan    <= w_is_nan;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: round, range-check, negate, saturate.
    // ------------------------------------------------------------------
    logic               w_inc;
    logic               w_inexact;
    logic               w_r1_huge;
    logic [OUT_W+1:0]   w_rnd;
    logic [OUT_W-1:0]   w_res;
    logic               w_nv;
    logic               w_nx;

    assign w_inexact = r1_guard | r1_sticky;
    assign w_r1_huge = (r1_exp > c_EXP_LIMIT);

    always_comb begin
        w_inc = 1'b0;
        case (r1_rm)
            c_RM_RTZ: w_inc = 1'b0;
            c_RM_RDN: w_inc = r1_sign & w_inexact;
            c_RM_RUP: w_inc = ~r1_sign & w_inexact;
            c_RM_RMM: w_inc = r1_guard;
            default:  w_inc = r1_guard & (r1_sticky | r1_int[0]);
        endcase
    end

    // Extra top bit keeps the carry out of rounding visible to the range
    // checks below.
    assign w_rnd = {1'b0, r1_int} + {{(OUT_W+1){1'b0}}, w_inc};

    always_comb begin
        w_res = '0;
        w_nv  = 1'b0;
        w_nx  = 1'b0;
        if (r1_nan) begin
            w_res = r1_uns ? c_ONES : c_SMAX;
            w_nv  = 1'b1;
        end else if (r1_uns) begin
            if (r1_sign) begin
                // Negative input: only a value that rounds to zero is legal.
                w_res = '0;
                if (w_r1_huge || (w_rnd != '0)) begin
                    w_nv = 1'b1;
                end else begin
                    w_nx = w_inexact;
                end
            end else if (w_r1_huge || (w_rnd > c_UMAX_MAG)) begin
                w_res = c_ONES;
                w_nv  = 1'b1;
            end else begin
                w_res = w_rnd[OUT_W-1:0];
                w_nx  = w_inexact;
            end
        end else begin
            if (r1_sign) begin
                if (w_r1_huge || (w_rnd > c_SMIN_MAG)) begin
                    w_res = c_SMIN;
                    w_nv  = 1'b1;
                end else begin
                    // A magnitude of exactly 2^(OUT_W-1) negates onto itself.
                    w_res = -w_rnd[OUT_W-1:0];
                    w_nx  = w_inexact;
                end
            end else if (w_r1_huge || (w_rnd > c_SMAX_MAG)) begin
                w_res = c_SMAX;
                w_nv  = 1'b1;
            end else begin
                w_res = w_rnd[OUT_W-1:0];
                w_nx  = w_inexact;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (outputs). Bubbles load zeros so an idle output
    // never shows stale data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            nv        <= 1'b0;
            nx        <= 1'b0;
        end else if (w_advance) begin
            out_valid <= r1_valid;
            result    <= r1_valid ? w_res : '0;
            nv        <= r1_valid & w_nv;
            nx        <= r1_valid & w_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ftoi_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ftoi_ext
//  Purpose  : Self-checking bench for ftoi_ext (OUT_W = 32). Directed corner
//             cases, back-pressure, mid-stream reset and a randomized stream
//             compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ftoi_ext;

    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      op = '0;
    logic [2:0]       rm = '0;
    logic             uns = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] result;
    logic             nv;
    logic             nx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [OUT_W+1:0] exp_q[$];
    int               acc_q[$];
    bit               check_lat = 1'b0;
    bit               use_fixed = 1'b0;
    logic [OUT_W+1:0] fixed_exp = '0;
    bit               last_acc = 1'b0;

    ftoi_ext #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rm        (rm),
        .uns       (uns),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .nv        (nv),
        .nx        (nx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference: exact value = mant * 2^(e-150), split into integer part and
    // remainder, rounded by comparing the remainder with one half, then
    // range-checked as a plain signed number.
    function automatic logic [OUT_W+1:0] model(input logic [31:0] f, input logic [2:0] rmi,
                                               input logic u);
        logic s;
        int e;
        int sh;
        logic [191:0] m, ip, rem, half, mag;
        bit inexact, gt, tie, inc;
        logic signed [199:0] v, smax, smin, umax;
        logic [OUT_W-1:0] smax_w, smin_w, ones_w;
        logic [OUT_W+1:0] res;
        s = f[31];
        e = int'(f[30:23]);
        smax = (200'sd1 <<< (OUT_W-1)) - 200'sd1;
        smin = -(200'sd1 <<< (OUT_W-1));
        umax = (200'sd1 <<< OUT_W) - 200'sd1;
        smax_w = smax[OUT_W-1:0];
        smin_w = smin[OUT_W-1:0];
        ones_w = umax[OUT_W-1:0];
        ip = '0; rem = '0; half = '0; m = '0;
        gt = 1'b0; tie = 1'b0; inexact = 1'b0; inc = 1'b0;
        if (e == 255) begin
            if (f[22:0] != 23'd0)  res = {2'b10, u ? ones_w : smax_w};
            else if (u)            res = {2'b10, s ? {OUT_W{1'b0}} : ones_w};
            else                   res = {2'b10, s ? smin_w : smax_w};
        end else begin
            if (e == 0) begin
                inexact = (f[22:0] != 23'd0);
            end else begin
                m = {168'b0, 1'b1, f[22:0]};
                if (e >= 150) begin
                    ip = m << (e - 150);
                end else begin
                    sh      = 150 - e;
                    ip      = m >> sh;
                    rem     = m - (ip << sh);
                    half    = 192'd1 << (sh - 1);
                    gt      = (rem > half);
                    tie     = (rem == half);
                    inexact = (rem != 192'd0);
                end
            end
            case (rmi)
                3'd1:    inc = 1'b0;
                3'd2:    inc = s & inexact;
                3'd3:    inc = !s & inexact;
                3'd4:    inc = gt | tie;
                default: inc = gt | (tie & ip[0]);
            endcase
            mag = ip + 192'(inc);
            v = $signed({8'b0, mag});
            if (s) v = -v;
            if (u) begin
                if (v > umax)      res = {2'b10, ones_w};
                else if (v < 0)    res = {2'b10, {OUT_W{1'b0}}};
                else               res = {1'b0, inexact, v[OUT_W-1:0]};
            end else begin
                if (v > smax)      res = {2'b10, smax_w};
                else if (v < smin) res = {2'b10, smin_w};
                else               res = {1'b0, inexact, v[OUT_W-1:0]};
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive after the falling edge, sample outputs 1 time
    // unit later, record acceptance/handshake, and return at the next
    // falling edge.
    task automatic tick(input logic iv, input logic [31:0] o, input logic [2:0] r,
                        input logic u, input logic ordy);
        logic hs;
        logic [OUT_W+1:0] e;
        int a;
        in_valid  = iv;
        op        = o;
        rm        = r;
        uns       = u;
        out_ready = ordy;
        #1;
        last_acc = iv & in_ready & ~reset;
        hs       = out_valid & ordy & ~reset;
        if (out_valid && !ordy && !reset)
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("result_nv_nx", 64'({nv, nx, result}), 64'(e));
                if (check_lat) chk("latency", 64'(cyc - a), 64'd2);
            end
        end
        if (last_acc) begin
            exp_q.push_back(use_fixed ? fixed_exp : model(o, r, u));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic dtick(input logic [31:0] o, input logic [2:0] r, input logic u,
                         input logic [OUT_W+1:0] e);
        use_fixed = 1'b1;
        fixed_exp = e;
        tick(1'b1, o, r, u, 1'b1);
        use_fixed = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] bp_ops[4];
    int          idx;
    int          stall;
    bit          seen;
    logic        ordy_v;
    logic [31:0] fr;
    logic [7:0]  ef;
    logic [31:0] rop;
    int          sel;

    initial begin
        bp_ops[0] = 32'h3F800000;
        bp_ops[1] = 32'h40000000;
        bp_ops[2] = 32'h40400000;
        bp_ops[3] = 32'h40800000;

        @(negedge clk);
        // Reset with input offered: nothing may be accepted.
        reset = 1'b1;
        tick(1'b1, 32'h3F800000, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 32'h40000000, 3'd0, 1'b0, 1'b0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result",    64'(result),    64'd0);
        chk("reset_nv",        64'(nv),        64'd0);
        chk("reset_nx",        64'(nx),        64'd0);
        reset = 1'b0;

        // Directed values, streamed back-to-back with latency checks.
        check_lat = 1'b1;
        dtick(32'h40200000, 3'd0, 1'b0, {2'b01, 32'd2});
        dtick(32'h40200000, 3'd4, 1'b0, {2'b01, 32'd3});
        dtick(32'hBFC00000, 3'd1, 1'b0, {2'b01, 32'hFFFFFFFF});
        dtick(32'hBFC00000, 3'd2, 1'b0, {2'b01, 32'hFFFFFFFE});
        dtick(32'hBFC00000, 3'd3, 1'b0, {2'b01, 32'hFFFFFFFF});
        dtick(32'hBFC00000, 3'd0, 1'b0, {2'b01, 32'hFFFFFFFE});
        dtick(32'h4F000000, 3'd0, 1'b0, {2'b10, 32'h7FFFFFFF});
        dtick(32'hCF000000, 3'd0, 1'b0, {2'b00, 32'h80000000});
        dtick(32'h4F000000, 3'd0, 1'b1, {2'b00, 32'h80000000});
        dtick(32'hBF800000, 3'd0, 1'b1, {2'b10, 32'h00000000});
        dtick(32'hBE800000, 3'd1, 1'b1, {2'b01, 32'h00000000});
        dtick(32'h7FC00000, 3'd0, 1'b0, {2'b10, 32'h7FFFFFFF});
        dtick(32'h7FC00000, 3'd0, 1'b1, {2'b10, 32'hFFFFFFFF});
        dtick(32'hFF800000, 3'd0, 1'b0, {2'b10, 32'h80000000});
        dtick(32'h80000000, 3'd0, 1'b0, {2'b00, 32'h00000000});
        dtick(32'h00000000, 3'd3, 1'b1, {2'b00, 32'h00000000});
        dtick(32'h7F800000, 3'd0, 1'b1, {2'b10, 32'hFFFFFFFF});
        dtick(32'h4F800000, 3'd0, 1'b1, {2'b10, 32'hFFFFFFFF});
        dtick(32'h4F7FFFFF, 3'd0, 1'b1, {2'b00, 32'hFFFFFF00});
        dtick(32'h00000001, 3'd3, 1'b0, {2'b01, 32'h00000001});
        drain();

        // Back-pressure: four values offered back-to-back, consumer stalls
        // for three cycles starting at the first out_valid.
        check_lat = 1'b0;
        idx   = 0;
        stall = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && (idx < 4 || exp_q.size() != 0); k++) begin
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            ordy_v = (stall == 0);
            if (stall > 0) stall--;
            if (idx < 4) begin
                use_fixed = 1'b1;
                fixed_exp = {2'b00, 32'(idx + 1)};
                tick(1'b1, bp_ops[idx], 3'd0, 1'b0, ordy_v);
                use_fixed = 1'b0;
                if (last_acc) idx++;
            end else begin
                tick(1'b0, '0, '0, 1'b0, ordy_v);
            end
        end
        chk("bp_all_sent", 64'(idx), 64'd4);
        drain();

        // Reset with two transactions in flight.
        tick(1'b1, 32'h40A00000, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 32'h40C00000, 3'd0, 1'b0, 1'b1);
        reset = 1'b1;
        tick(1'b1, 32'h40E00000, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result",    64'(result),    64'd0);
        drain();
        check_lat = 1'b1;
        dtick(32'h41100000, 3'd0, 1'b0, {2'b00, 32'd9});
        drain();

        // Randomized stream with random valid and ready.
        check_lat = 1'b0;
        for (int n = 0; n < 500; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ef = 8'h00;
            else if (sel == 1) ef = 8'hFF;
            else               ef = 8'($urandom_range(100, 165));
            fr = $urandom;
            if ($urandom_range(0, 3) == 0) fr[15:0] = 16'h0000;
            rop = {1'($urandom), ef, fr[22:0]};
            tick(1'($urandom_range(0, 4) != 0), rop, 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
